// File: rtl/shift_pkg.sv
// Shared types and level-partitioning helpers for the pipelined shift unit.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL  = 2'b00,
    SH_SRL  = 2'b01,
    SH_SRA  = 2'b10,
    SH_ROTL = 2'b11
  } shift_mode_e;

  // Control half of the stage payload; data and shamt widths follow DATA_W in the modules.
  typedef struct packed {
    shift_mode_e mode;
    logic        sign;
  } shift_ctrl_t;

  function automatic int levelsPerStage(int shamtW, int numStages);
    return (shamtW + numStages - 1) / numStages;
  endfunction

  // Later stages may be left with no levels when the split does not divide evenly.
  function automatic int stageLevels(int shamtW, int numStages, int stage);
    int per;
    int left;
    per  = levelsPerStage(shamtW, numStages);
    left = shamtW - stage * per;
    if (left <= 0) return 0;
    return (left < per) ? left : per;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: NUM_LVL log-shifter levels starting at FIRST_LVL, then a held register.
// SHIFT_ROTATE_EN builds the rotate path; without it mode 11 falls through to SLL.
module shift_stage
  import shift_pkg::*;
#(
  parameter int  DATA_W    = 32,
  parameter int  FIRST_LVL = 0,
  parameter int  NUM_LVL   = 1,
  localparam int SHAMT_W   = $clog2(DATA_W)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               advance,
  input  logic               inValid,
  input  logic [DATA_W-1:0]  inData,
  input  logic [SHAMT_W-1:0] inShamt,
  input  shift_ctrl_t        inCtrl,
  output logic               outValid,
  output logic [DATA_W-1:0]  outData,
  output logic [SHAMT_W-1:0] outShamt,
  output shift_ctrl_t        outCtrl
);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] shamt;
    shift_ctrl_t        ctrl;
  } payload_t;

  logic [DATA_W-1:0] lvlData [NUM_LVL+1];
  payload_t          stageReg;
  logic              validReg;

  assign lvlData[0] = inData;

  for (genvar j = 0; j < NUM_LVL; j++) begin : gLvl
    localparam int AMT = 1 << (FIRST_LVL + j);
    logic [DATA_W-1:0] shifted;

    // NOTE: the default assignment comes first so no path leaves shifted unassigned (no latch).
    always_comb begin
      shifted = lvlData[j] << AMT;
      case (inCtrl.mode)
        SH_SRL:  shifted = lvlData[j] >> AMT;
        // Fill from the operand's original MSB, not the partially shifted word.
        SH_SRA:  shifted = (lvlData[j] >> AMT) | (inCtrl.sign ? ~({DATA_W{1'b1}} >> AMT) : '0);
`ifdef SHIFT_ROTATE_EN
        SH_ROTL: shifted = (lvlData[j] << AMT) | (lvlData[j] >> (DATA_W - AMT));
`endif
        default: ;
      endcase
    end

    assign lvlData[j+1] = inShamt[FIRST_LVL+j] ? shifted : lvlData[j];
  end

  // NOTE: nonblocking assignments let every stage sample its predecessor's old value on the edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      validReg <= 1'b0;
      stageReg <= '0;
    end else if (advance) begin
      validReg <= inValid;
      stageReg <= '{data: lvlData[NUM_LVL], shamt: inShamt, ctrl: inCtrl};
    end
  end

  assign outValid = validReg;
  assign outData  = stageReg.data;
  assign outShamt = stageReg.shamt;
  assign outCtrl  = stageReg.ctrl;

endmodule

// File: rtl/pipelined_shift_unit.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROTL) with valid/ready and a global stall.
// Define SHIFT_ROTATE_EN to enable rotate; otherwise mode 11 executes as SLL.
module pipelined_shift_unit
  import shift_pkg::*;
#(
  parameter int  DATA_W     = 32,
  parameter int  NUM_STAGES = 2,
  localparam int SHAMT_W    = $clog2(DATA_W)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data
);

  localparam int LVLS_PER_STAGE = levelsPerStage(SHAMT_W, NUM_STAGES);

  logic               stValid [NUM_STAGES+1];
  logic [DATA_W-1:0]  stData  [NUM_STAGES+1];
  logic [SHAMT_W-1:0] stShamt [NUM_STAGES+1];
  shift_ctrl_t        stCtrl  [NUM_STAGES+1];
  logic               advance;
  logic               unusedTail;

  // Whole pipe moves or holds together; bubbles are kept rather than squeezed out.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign stValid[0] = in_valid;
  assign stData[0]  = in_data;
  assign stShamt[0] = in_shamt;
  assign stCtrl[0]  = '{mode: shift_mode_e'(in_mode), sign: in_data[DATA_W-1]};

  for (genvar k = 0; k < NUM_STAGES; k++) begin : gStage
    shift_stage #(
      .DATA_W   (DATA_W),
      .FIRST_LVL(k * LVLS_PER_STAGE),
      .NUM_LVL  (stageLevels(SHAMT_W, NUM_STAGES, k))
    ) uStage (
      .Clk     (Clk),
      .Reset   (Reset),
      .advance (advance),
      .inValid (stValid[k]),
      .inData  (stData[k]),
      .inShamt (stShamt[k]),
      .inCtrl  (stCtrl[k]),
      .outValid(stValid[k+1]),
      .outData (stData[k+1]),
      .outShamt(stShamt[k+1]),
      .outCtrl (stCtrl[k+1])
    );
  end

  assign out_valid  = stValid[NUM_STAGES];
  assign out_data   = stData[NUM_STAGES];
  assign unusedTail = ^{stShamt[NUM_STAGES], stCtrl[NUM_STAGES]};

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Scoreboard bench: directed vectors on a 32-bit/2-stage unit plus random sweeps on other shapes.
module tb_pipelined_shift_unit;

`ifdef SHIFT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  logic swReset;
  always #5 Clk = ~Clk;

  int cycle = 0;
  always @(posedge Clk) cycle <= cycle + 1;

  int passCnt  = 0;
  int totalCnt = 0;

  typedef struct {
    logic [63:0] data;
    int          cyc;
    bit          chkLat;
  } sb_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  sh;
    logic [1:0]  m;
    logic [31:0] e;
  } vec_t;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] refShift(logic [63:0] d, int w, int sh, logic [1:0] mode);
    logic [63:0] mask;
    logic [63:0] x;
    logic [63:0] r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x    = d & mask;
    case (mode)
      2'd0:    r = x << sh;
      2'd1:    r = x >> sh;
      2'd2:    r = (x >> sh) | (x[w-1] ? (mask & ~(mask >> sh)) : 64'd0);
      default: r = ROT_EN ? ((x << sh) | ((sh == 0) ? 64'd0 : (x >> (w - sh)))) : (x << sh);
    endcase
    return r & mask;
  endfunction

  // ---------------- main DUT: DATA_W=32, NUM_STAGES=2 ----------------
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_mode;
  sb_t         sbQ[$];

  pipelined_shift_unit #(.DATA_W(32), .NUM_STAGES(2)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  task automatic send(logic [31:0] d, logic [4:0] sh, logic [1:0] m, logic [31:0] e,
                      bit push, bit chkLat);
    int waitCnt;
    waitCnt = 0;
    @(negedge Clk);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_mode  = m;
    #1;
    while (!in_ready && waitCnt < 50) begin
      @(negedge Clk);
      #1;
      waitCnt++;
    end
    if (!in_ready) begin
      totalCnt++;
      $display("FAIL send handshake: in_ready stuck at 0 for %0d cycles, expected 1", waitCnt);
      in_valid = 1'b0;
    end else begin
      if (push) sbQ.push_back('{{32'h0, e}, cycle, chkLat});
      @(posedge Clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("scoreboard drained", sbQ.size(), 0);
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    sb_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          totalCnt++;
          $display("FAIL unexpected output: got 0x%0h, expected no result", out_data);
        end else begin
          e = sbQ.pop_front();
          check("out_data", out_data, e.data);
          if (e.chkLat) check("latency", cycle - e.cyc, 2);
        end
      end
    end
  end

  // ---------------- sweeps: random beats vs reference model ----------------
  function automatic int swW(int g);
    return (g < 2) ? 8 : 64;
  endfunction

  function automatic int swS(int g);
    case (g)
      0, 2:    return 1;
      1, 3:    return 3;
      default: return 5;
    endcase
  endfunction

  for (genvar g = 0; g < 5; g++) begin : gSweep
    localparam int W  = swW(g);
    localparam int S  = swS(g);
    localparam int SW = $clog2(W);
    logic          vIn, rdy, vOut;
    logic [W-1:0]  dIn, dOut;
    logic [SW-1:0] sh;
    logic [1:0]    md;
    sb_t           q[$];
    bit            done = 1'b0;

    pipelined_shift_unit #(.DATA_W(W), .NUM_STAGES(S)) uSw (
      .Clk      (Clk),
      .Reset    (swReset),
      .in_valid (vIn),
      .in_ready (rdy),
      .in_data  (dIn),
      .in_shamt (sh),
      .in_mode  (md),
      .out_valid(vOut),
      .out_ready(1'b1),
      .out_data (dOut)
    );

    initial begin
      logic [63:0] r;
      vIn = 1'b0;
      dIn = '0;
      sh  = '0;
      md  = 2'd0;
      repeat (6) @(negedge Clk);
      for (int n = 0; n < 60; n++) begin
        @(negedge Clk);
        r   = {$urandom, $urandom};
        vIn = ($urandom_range(0, 3) != 0);
        dIn = r[W-1:0];
        sh  = SW'($urandom_range(0, W - 1));
        md  = 2'($urandom_range(0, 3));
        #1;
        if (vIn && rdy) q.push_back('{refShift(r, W, int'(sh), md), cycle, 1'b1});
      end
      @(negedge Clk);
      vIn = 1'b0;
      repeat (S + 3) @(negedge Clk);
      check($sformatf("sweep W%0d S%0d drained", W, S), q.size(), 0);
      done = 1'b1;
    end

    initial begin
      sb_t e;
      forever begin
        @(negedge Clk);
        #2;
        if (vOut) begin
          if (q.size() == 0) begin
            totalCnt++;
            $display("FAIL sweep W%0d S%0d unexpected output: got 0x%0h, expected no result",
                     W, S, dOut);
          end else begin
            e = q.pop_front();
            check($sformatf("sweep W%0d S%0d data", W, S), dOut, e.data);
            check($sformatf("sweep W%0d S%0d latency", W, S), cycle - e.cyc, S);
          end
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  vec_t vecs[$];
  vec_t stream[$];

  initial begin
    int n;
    Reset     = 1'b1;
    swReset   = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_mode   = 2'd0;
    out_ready = 1'b1;

    vecs.push_back('{32'h0000_0001, 5'd2,  2'd0, 32'h0000_0004});
    vecs.push_back('{32'h8000_00F0, 5'd4,  2'd1, 32'h0800_000F});
    vecs.push_back('{32'h8000_00F0, 5'd4,  2'd2, 32'hF800_000F});
    vecs.push_back('{32'hF000_0001, 5'd4,  2'd3, ROT_EN ? 32'h0000_001F : 32'h0000_0010});
    vecs.push_back('{32'hDEAD_BEEF, 5'd0,  2'd0, 32'hDEAD_BEEF});
    vecs.push_back('{32'hDEAD_BEEF, 5'd0,  2'd1, 32'hDEAD_BEEF});
    vecs.push_back('{32'hDEAD_BEEF, 5'd0,  2'd2, 32'hDEAD_BEEF});
    vecs.push_back('{32'hDEAD_BEEF, 5'd0,  2'd3, 32'hDEAD_BEEF});
    vecs.push_back('{32'hFFFF_FFFF, 5'd31, 2'd0, 32'h8000_0000});
    vecs.push_back('{32'h8000_0000, 5'd31, 2'd1, 32'h0000_0001});
    vecs.push_back('{32'h8000_0000, 5'd31, 2'd2, 32'hFFFF_FFFF});
    vecs.push_back('{32'h0000_0003, 5'd31, 2'd3, ROT_EN ? 32'h8000_0001 : 32'h8000_0000});
    vecs.push_back('{32'h7000_0000, 5'd8,  2'd2, 32'h0070_0000});
    vecs.push_back('{32'h1234_5678, 5'd13, 2'd0, 32'h8ACF_0000});
    vecs.push_back('{32'h1234_5678, 5'd13, 2'd1, 32'h0000_91A2});
    vecs.push_back('{32'h1234_5678, 5'd13, 2'd3, ROT_EN ? 32'h8ACF_0246 : 32'h8ACF_0000});

    stream.push_back('{32'h0000_00FF, 5'd8,  2'd0, 32'h0000_FF00});
    stream.push_back('{32'hFF00_0000, 5'd8,  2'd1, 32'h00FF_0000});
    stream.push_back('{32'h8000_0000, 5'd1,  2'd2, 32'hC000_0000});
    stream.push_back('{32'h0000_0001, 5'd16, 2'd0, 32'h0001_0000});
    stream.push_back('{32'h1234_5678, 5'd0,  2'd2, 32'h1234_5678});

    repeat (3) @(negedge Clk);
    Reset   = 1'b0;
    swReset = 1'b0;
    #2;
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset in_ready", in_ready, 1);

    // Directed vectors, latency checked on each.
    foreach (vecs[i]) send(vecs[i].d, vecs[i].sh, vecs[i].m, vecs[i].e, 1'b1, 1'b1);
    drain();

    // Back-pressure: 5-beat stream with out_ready low for 3 cycles mid-stream.
    fork
      begin
        foreach (stream[i]) send(stream[i].d, stream[i].sh, stream[i].m, stream[i].e, 1'b1, 1'b0);
      end
      begin
        repeat (3) @(negedge Clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge Clk);
          #2;
          check("stall in_ready", in_ready, 0);
          check("stall out_valid", out_valid, 1);
          check("stall out_data", out_data, stream[0].e);
        end
        @(negedge Clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight: neither may ever reach the output.
    @(negedge Clk);
    out_ready = 1'b0;
    send(32'h0000_00AA, 5'd1, 2'd0, 32'h0, 1'b0, 1'b0);
    send(32'h0000_00BB, 5'd2, 2'd0, 32'h0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset     = 1'b0;
    out_ready = 1'b1;
    #2;
    check("mid-flight reset out_valid", out_valid, 0);
    check("mid-flight reset out_data", out_data, 0);
    check("post-reset in_ready", in_ready, 1);

    // A beat offered while Reset is high is accepted by the handshake but dropped.
    @(negedge Clk);
    Reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hA5A5_A5A5;
    in_shamt = 5'd1;
    in_mode  = 2'd0;
    #1;
    check("in_ready during reset", in_ready, 1);
    @(negedge Clk);
    Reset    = 1'b0;
    in_valid = 1'b0;
    repeat (5) @(negedge Clk);
    send(32'h0000_0100, 5'd4, 2'd0, 32'h0000_1000, 1'b1, 1'b1);
    drain();

    n = 0;
    while (!(gSweep[0].done && gSweep[1].done && gSweep[2].done && gSweep[3].done &&
             gSweep[4].done) && n < 500) begin
      @(negedge Clk);
      n++;
    end
    if (!(gSweep[0].done && gSweep[1].done && gSweep[2].done && gSweep[3].done &&
          gSweep[4].done)) begin
      totalCnt++;
      $display("FAIL sweep completion: still running after %0d cycles, expected done", n);
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
